// File: rtl/isqrt_pkg.sv
// Purpose : shared types and width helpers for the sequential integer square root.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Root width is half the radicand width.
  function automatic int out_w_of(input int in_w);
    return in_w / 2;
  endfunction

  // Reported remainder spans 0..2*root, one bit wider than the root.
  function automatic int rem_w_of(input int out_w);
    return out_w + 1;
  endfunction

  // Iteration counter holds OUT_W-1 down to 0; keep at least one bit.
  function automatic int cnt_w_of(input int out_w);
    return (out_w > 1) ? $clog2(out_w) : 1;
  endfunction

  localparam int DEF_IN_W  = 14;
  localparam int DEF_OUT_W = out_w_of(DEF_IN_W);
  localparam int DEF_REM_W = rem_w_of(DEF_OUT_W);
  localparam int DEF_CNT_W = cnt_w_of(DEF_OUT_W);

endpackage

// File: rtl/isqrt_step.sv
// Purpose : one restoring digit step of the square root (combinational).
// Latency : 0 cycles.
// Backpr. : none; pure function of its inputs.
// Ports   : rem_p/root_p = partial remainder/root, next2bits = next radicand
//           digit pair; rem_n/root_n = updated partial remainder/root.
module isqrt_step #(
  parameter int OUT_W = 7
) (
  input  logic [OUT_W+1:0] rem_p,
  input  logic [OUT_W-1:0] root_p,
  input  logic [1:0]       next2bits,
  output logic [OUT_W+1:0] rem_n,
  output logic [OUT_W-1:0] root_n
);

  localparam int RP_W = OUT_W + 2;

  logic [RP_W+1:0] dividend;
  logic [RP_W-1:0] sub;
  logic [RP_W-1:0] diff;
  logic            ge;

  always_comb begin
    dividend = {rem_p, next2bits};
    sub      = {root_p, 2'b01};
    // Compare at full width so nothing is lost before the decision.
    ge       = (dividend >= {2'b00, sub});
    // When ge holds the true difference fits RP_W bits, so modular low-bit
    // subtraction gives the exact result.
    diff     = dividend[RP_W-1:0] - sub;
    rem_n    = ge ? diff : dividend[RP_W-1:0];
    root_n   = OUT_W'({root_p, ge});
  end

endmodule

// File: rtl/isqrt_seq.sv
// Purpose : sequential unsigned integer square root, floor root + remainder.
// Latency : OUT_W cycles from accept edge to out_valid; II = OUT_W+2 cycles.
// Backpr. : result held in DONE until out_ready; in_ready low while busy, no input buffering.
// Ports   : clk, rst_n (async active-low); in_valid/in_ready/radicand input
//           handshake; out_valid/out_ready/root/rem result handshake.
// Option  : define ISQRT_ROUND_EN to round root to nearest (saturating at
//           2^OUT_W-1); rem stays floor-based.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter  int IN_W  = DEF_IN_W,
  localparam int OUT_W = IN_W / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  radicand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] root,
  output logic [OUT_W:0]   rem
);

  localparam int RP_W  = OUT_W + 2;
  localparam int CNT_W = cnt_w_of(OUT_W);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  sh_q, sh_d;
  logic [RP_W-1:0]  rem_q, rem_d;
  logic [OUT_W-1:0] root_q, root_d;

  logic [RP_W-1:0]  step_rem;
  logic [OUT_W-1:0] step_root;
  logic             rem_msb_unused;

  isqrt_step #(.OUT_W(OUT_W)) u_step (
    .rem_p     (rem_q),
    .root_p    (root_q),
    .next2bits (sh_q[IN_W-1 -: 2]),
    .rem_n     (step_rem),
    .root_n    (step_root)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    root_d  = root_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = radicand;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CNT_W'(OUT_W - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        sh_d   = sh_q << 2;
        rem_d  = step_rem;
        root_d = step_root;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = DONE;
`ifdef ISQRT_ROUND_EN
          // x >= (r+0.5)^2 reduces to rem > r for integers.
          if ((step_rem > {2'b00, step_root}) && (step_root != '1)) begin
            root_d = step_root + 1'b1;
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rem_q   <= '0;
      root_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
    end
  end

  // Final remainder never exceeds 2*root, so the internal guard bit is not reported.
  assign rem_msb_unused = rem_q[RP_W-1];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign root      = root_q;
  assign rem       = rem_q[OUT_W:0];

endmodule

// File: tb/tb_isqrt_seq.sv
module tb_isqrt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] radicand = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  root;
  logic [7:0]  rem;

`ifdef ISQRT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  isqrt_seq #(.IN_W(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .radicand  (radicand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int x;
    int r_floor;
    int r_round;
    int m;
  } vec_t;

  vec_t vecs[12];

  function automatic int ref_root(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Called just after a rising edge with the unit idle. Returns cycles from
  // the accept edge until out_valid is seen (capped).
  task automatic send(input int x, output int lat);
    check("in_ready_before_accept", int'(in_ready), 1);
    in_valid = 1'b1;
    radicand = 14'(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
    radicand = ~14'(x);   // must not influence the result
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int prev;
    int x, er, em;

    vecs[0]  = '{0,     0,   0,   0};
    vecs[1]  = '{16383, 127, 127, 254};
    vecs[2]  = '{144,   12,  12,  0};
    vecs[3]  = '{150,   12,  12,  6};
    vecs[4]  = '{160,   12,  13,  16};
    vecs[5]  = '{1,     1,   1,   0};
    vecs[6]  = '{2,     1,   1,   1};
    vecs[7]  = '{3,     1,   2,   2};
    vecs[8]  = '{15,    3,   4,   6};
    vecs[9]  = '{16,    4,   4,   0};
    vecs[10] = '{12,    3,   3,   3};
    vecs[11] = '{8191,  90,  91,  91};

    // Reset state.
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_root", int'(root), 0);
    check("rst_rem", int'(rem), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid_after", int'(out_valid), 0);

    // Directed table.
    foreach (vecs[i]) begin
      send(vecs[i].x, lat);
      check($sformatf("latency_%0d", vecs[i].x), lat, 7);
      check($sformatf("root_%0d", vecs[i].x), int'(root),
            ROUND ? vecs[i].r_round : vecs[i].r_floor);
      check($sformatf("rem_%0d", vecs[i].x), int'(rem), vecs[i].m);
      take();
      check("out_valid_after_take", int'(out_valid), 0);
      check("in_ready_after_take", int'(in_ready), 1);
    end

    // Backpressure: hold result for 5 cycles while another radicand is offered.
    send(150, lat);
    check("bp_latency", lat, 7);
    in_valid = 1'b1;
    radicand = 14'd49;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_root", int'(root), 12);
      check("bp_rem", int'(rem), 6);
    end
    in_valid = 1'b0;
    take();
    check("bp_idle_in_ready", int'(in_ready), 1);
    check("bp_idle_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    check("bp_not_accepted", int'(in_ready), 1);

    // Reset during the 3rd CALC cycle.
    in_valid = 1'b1;
    radicand = 14'd16383;
    @(posedge clk); #1;           // accept
    in_valid = 1'b0;
    @(posedge clk); #1;           // step 1
    @(posedge clk); #1;           // step 2, now in 3rd CALC cycle
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_root", int'(root), 0);
    check("midrst_rem", int'(rem), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", int'(in_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_stale", int'(out_valid), 0);
    send(49, lat);
    check("midrst_lat", lat, 7);
    check("midrst_root49", int'(root), 7);
    check("midrst_rem49", int'(rem), 0);
    take();

    // Back-to-back with in_valid and out_ready high; strided sweep + endpoint.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev = -1;
    for (int k = 0; k <= 2341; k++) begin
      x = (k == 2341) ? 16383 : k * 7;
      radicand = 14'(x);
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!out_valid && lat < 20);
      er = ref_root(x);
      em = x - er * er;
      if (ROUND && em > er && er < 127) er = er + 1;
      check($sformatf("b2b_valid_%0d", x), int'(out_valid), 1);
      check($sformatf("b2b_root_%0d", x), int'(root), er);
      check($sformatf("b2b_rem_%0d", x), int'(rem), em);
      if (prev >= 0) check("b2b_interval", cyc - prev, 9);
      prev = cyc;
      @(posedge clk); #1;   // output handshake edge
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
